// File: rtl/bet_bank_ctrl.sv
//------------------------------------------------------------------------------
// Module      : bet_bank_ctrl
// Description : Betting and bankroll controller for the FPGA blackjack game.
//               Synchronises and edge-detects the raw bet buttons, accumulates
//               a saturating bet, locks it for a round, and settles the signed
//               bankroll from the game FSM's outcome report (3:2 blackjack).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk              system clock
//   rst              asynchronous, active-low reset
//   inc_btn_i        raw level-high bet increment buttons (asynchronous)
//   clear_btn_i      raw button, zeroes the bet while betting (asynchronous)
//   start_btn_i      raw button, locks the bet and starts a round (asynchronous)
//   outcome_valid_i  one-cycle outcome pulse from the game FSM
//   outcome_i        00 loss, 01 tie, 10 win, 11 blackjack win
//   bet_o            current bet
//   bank_o           signed bankroll (two's complement)
//   round_active_o   high while a round is locked or settling
//   settle_valid_o   one-cycle pulse after the bank has been credited
//   broke_o          registered flag, bank <= 0
//------------------------------------------------------------------------------

`default_nettype none

module bet_bank_ctrl #(
    parameter int                   NUM_INC    = 4,
    parameter logic [NUM_INC*8-1:0] INC_VALS   = {8'd25, 8'd10, 8'd5, 8'd1},
    parameter int                   BET_W      = 8,
    parameter int                   BET_MAX    = 99,
    parameter int                   BANK_W     = 12,
    parameter int                   START_BANK = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INC-1:0] inc_btn_i,
    input  logic               clear_btn_i,
    input  logic               start_btn_i,
    input  logic               outcome_valid_i,
    input  logic [1:0]         outcome_i,
    output logic [BET_W-1:0]   bet_o,
    output logic [BANK_W-1:0]  bank_o,
    output logic               round_active_o,
    output logic               settle_valid_o,
    output logic               broke_o
);

    // All buttons share one synchroniser/edge-detector vector:
    // bit NUM_INC+1 = start, bit NUM_INC = clear, lower bits = increments.
    localparam int NBTN  = NUM_INC + 2;
    localparam int SUM_W = BET_W + 4;
    localparam int PAY_W = BET_W + 2;
    // Wide enough for the sign-extended bank and the largest payout so the
    // saturation test sees the true result.
    localparam int ACC_W = ((BANK_W > BET_W + 3) ? BANK_W : BET_W + 3) + 1;

    localparam logic [SUM_W-1:0] C_BET_MAX = SUM_W'(BET_MAX);
    localparam logic signed [ACC_W-1:0] C_BANK_MAX =
        {{(ACC_W-BANK_W+1){1'b0}}, {(BANK_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_BANK_MIN =
        {{(ACC_W-BANK_W+1){1'b1}}, {(BANK_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_BETTING = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_SETTLE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BET_W-1:0]   bet_q, bet_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [PAY_W-1:0]   payout_q, payout_d;
    logic               settle_q, settle_d;
    logic               broke_q, broke_d;

    logic [NBTN-1:0]    sync1_q, sync2_q, prev_q;

    logic [NBTN-1:0]          w_btn_raw;
    logic [NBTN-1:0]          w_edge;
    logic [NUM_INC-1:0]       w_inc_edge;
    logic                     w_clear_edge;
    logic                     w_start_edge;
    logic [SUM_W-1:0]         w_inc_sum;
    logic [SUM_W-1:0]         w_bet_sum;
    logic [BET_W-1:0]         w_bet_inc;
    logic signed [ACC_W-1:0]  w_bank_ext;
    logic signed [ACC_W-1:0]  w_bet_ext;
    logic signed [ACC_W-1:0]  w_pay_ext;
    logic [BANK_W-1:0]        w_bank_debit;
    logic [BANK_W-1:0]        w_bank_credit;

    function automatic logic [BANK_W-1:0] sat_bank(input logic signed [ACC_W-1:0] v);
        logic [BANK_W-1:0] r;
        if (v > C_BANK_MAX) begin
            r = C_BANK_MAX[BANK_W-1:0];
        end else if (v < C_BANK_MIN) begin
            r = C_BANK_MIN[BANK_W-1:0];
        end else begin
            r = v[BANK_W-1:0];
        end
        return r;
    endfunction

    //--------------------------------------------------------------------------
    // Button synchronisers and rising-edge detectors
    //--------------------------------------------------------------------------
    assign w_btn_raw    = {start_btn_i, clear_btn_i, inc_btn_i};
    assign w_edge       = sync2_q & ~prev_q;
    assign w_inc_edge   = w_edge[NUM_INC-1:0];
    assign w_clear_edge = w_edge[NUM_INC];
    assign w_start_edge = w_edge[NUM_INC+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= w_btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    //--------------------------------------------------------------------------
    // Bet accumulation (sum of all denominations pressed this cycle)
    //--------------------------------------------------------------------------
    always_comb begin
        w_inc_sum = '0;
        for (int i = 0; i < NUM_INC; i++) begin
            if (w_inc_edge[i]) begin
                w_inc_sum = w_inc_sum + SUM_W'(INC_VALS[8*i +: 8]);
            end
        end
    end

    assign w_bet_sum = {4'b0000, bet_q} + w_inc_sum;
    assign w_bet_inc = (w_bet_sum > C_BET_MAX) ? C_BET_MAX[BET_W-1:0]
                                               : w_bet_sum[BET_W-1:0];

    //--------------------------------------------------------------------------
    // Bank arithmetic: debit at lock, credit at settle, both saturating
    //--------------------------------------------------------------------------
    assign w_bank_ext    = {{(ACC_W-BANK_W){bank_q[BANK_W-1]}}, bank_q};
    assign w_bet_ext     = {{(ACC_W-BET_W){1'b0}}, bet_q};
    assign w_pay_ext     = {{(ACC_W-PAY_W){1'b0}}, payout_q};
    assign w_bank_debit  = sat_bank(w_bank_ext - w_bet_ext);
    assign w_bank_credit = sat_bank(w_bank_ext + w_pay_ext);

    //--------------------------------------------------------------------------
    // Round FSM: next state and datapath updates
    //--------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        bet_d    = bet_q;
        bank_d   = bank_q;
        payout_d = payout_q;
        settle_d = 1'b0;
        broke_d  = bank_q[BANK_W-1] | (bank_q == '0);

        case (state_q)
            ST_BETTING: begin
                // Start wins over clear and increments; the lock keeps the
                // pre-cycle bet. A start with no bet falls through.
                if (w_start_edge && (bet_q != '0)) begin
                    bank_d  = w_bank_debit;
                    state_d = ST_LOCKED;
                end else if (w_clear_edge) begin
                    bet_d = '0;
                end else if (|w_inc_edge) begin
                    bet_d = w_bet_inc;
                end
            end

            ST_LOCKED: begin
                if (outcome_valid_i) begin
                    case (outcome_i)
                        2'b00:   payout_d = '0;
                        2'b01:   payout_d = {2'b00, bet_q};
                        2'b10:   payout_d = {1'b0, bet_q, 1'b0};
                        default: payout_d = {1'b0, bet_q, 1'b0}
                                          + {3'b000, bet_q[BET_W-1:1]};
                    endcase
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                bank_d   = w_bank_credit;
                bet_d    = '0;
                settle_d = 1'b1;
                state_d  = ST_BETTING;
            end

            default: begin
                state_d = ST_BETTING;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_BETTING;
            bet_q    <= '0;
            bank_q   <= BANK_W'(START_BANK);
            payout_q <= '0;
            settle_q <= 1'b0;
            broke_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bet_q    <= bet_d;
            bank_q   <= bank_d;
            payout_q <= payout_d;
            settle_q <= settle_d;
            broke_q  <= broke_d;
        end
    end

    assign bet_o          = bet_q;
    assign bank_o         = bank_q;
    assign round_active_o = (state_q == ST_LOCKED) || (state_q == ST_SETTLE);
    assign settle_valid_o = settle_q;
    assign broke_o        = broke_q;

endmodule

`default_nettype wire

// File: tb/tb_bet_bank_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_bet_bank_ctrl
// Description : Self-checking bench for bet_bank_ctrl. Directed and random
//               button/outcome stimulus against a behavioural bankroll model;
//               settlement results are checked through a scoreboard queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`timescale 1ns/1ps
`default_nettype none

module tb_bet_bank_ctrl;

    localparam int BET_W   = 8;
    localparam int BET_MAX = 99;
    localparam int BANK_W  = 12;
    localparam int START   = 200;
    localparam int BANK_HI = (1 << (BANK_W - 1)) - 1;
    localparam int BANK_LO = -(1 << (BANK_W - 1));

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        inc_btn = '0;
    logic              clear_btn = 1'b0;
    logic              start_btn = 1'b0;
    logic              outcome_valid = 1'b0;
    logic [1:0]        outcome = '0;
    logic [BET_W-1:0]  bet_o;
    logic [BANK_W-1:0] bank_o;
    logic              round_active_o;
    logic              settle_valid_o;
    logic              broke_o;

    bet_bank_ctrl #(
        .NUM_INC    (4),
        .INC_VALS   ({8'd25, 8'd10, 8'd5, 8'd1}),
        .BET_W      (BET_W),
        .BET_MAX    (BET_MAX),
        .BANK_W     (BANK_W),
        .START_BANK (START)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inc_btn_i       (inc_btn),
        .clear_btn_i     (clear_btn),
        .start_btn_i     (start_btn),
        .outcome_valid_i (outcome_valid),
        .outcome_i       (outcome),
        .bet_o           (bet_o),
        .bank_o          (bank_o),
        .round_active_o  (round_active_o),
        .settle_valid_o  (settle_valid_o),
        .broke_o         (broke_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_bet    = 0;
    int m_bank   = START;
    bit m_locked = 1'b0;
    int inc_val [4] = '{1, 5, 10, 25};

    int exp_q [$];   // expected bank after each settlement
    bit prev_settle = 1'b0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat(int v);
        if (v > BANK_HI) return BANK_HI;
        if (v < BANK_LO) return BANK_LO;
        return v;
    endfunction

    function automatic int bank_now();
        return int'($signed(bank_o));
    endfunction

    // Monitor: every settle pulse must match the oldest expected settlement
    always @(negedge clk) begin
        if (rst) begin
            if (settle_valid_o) begin
                chk("settle_single_cycle", int'(prev_settle), 0);
                if (exp_q.size() == 0) begin
                    chk("settle_unexpected", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("settle_bank", bank_now(), e);
                    chk("settle_bet", int'(bet_o), 0);
                end
            end
            prev_settle = settle_valid_o;
        end else begin
            prev_settle = 1'b0;
        end
    end

    task automatic check_state(string tag);
        chk({tag, "_bet"}, int'(bet_o), m_bet);
        chk({tag, "_bank"}, bank_now(), m_bank);
        chk({tag, "_active"}, int'(round_active_o), int'(m_locked));
    endtask

    // One button press: held three cycles, then released long enough for the
    // edge detector to rearm.
    task automatic press(input logic [3:0] inc, input bit clr, input bit st);
        int sum;
        @(negedge clk);
        inc_btn = inc; clear_btn = clr; start_btn = st;
        repeat (3) @(negedge clk);
        inc_btn = '0; clear_btn = 1'b0; start_btn = 1'b0;
        repeat (4) @(negedge clk);
        if (!m_locked) begin
            sum = 0;
            for (int i = 0; i < 4; i++) if (inc[i]) sum += inc_val[i];
            if (st && m_bet != 0) begin
                m_bank   = sat(m_bank - m_bet);
                m_locked = 1'b1;
            end else if (clr) begin
                m_bet = 0;
            end else begin
                m_bet = (m_bet + sum > BET_MAX) ? BET_MAX : m_bet + sum;
            end
        end
        check_state("press");
        chk("press_broke", int'(broke_o), int'(m_bank <= 0));
    endtask

    task automatic do_outcome(input logic [1:0] oc);
        int pay;
        @(negedge clk);
        outcome_valid = 1'b1; outcome = oc;
        @(negedge clk);
        outcome_valid = 1'b0; outcome = 2'($urandom);
        if (m_locked) begin
            case (oc)
                2'd0: pay = 0;
                2'd1: pay = m_bet;
                2'd2: pay = 2 * m_bet;
                default: pay = 2 * m_bet + m_bet / 2;
            endcase
            m_bank   = sat(m_bank + pay);
            m_bet    = 0;
            m_locked = 1'b0;
            exp_q.push_back(m_bank);
            for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
            if (exp_q.size() != 0) begin
                chk("settle_timeout", 1, 0);
                exp_q.delete();
            end
        end
        repeat (3) @(negedge clk);
        check_state("outcome");
        chk("outcome_broke", int'(broke_o), int'(m_bank <= 0));
    endtask

    task automatic set_bet99_round(input logic [1:0] oc);
        repeat (4) press(4'b1000, 1'b0, 1'b0);
        press(4'b0000, 1'b0, 1'b1);
        do_outcome(oc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_state("reset");
        chk("reset_broke", int'(broke_o), 0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            quiet = quiet | int'(settle_valid_o);
        end
        chk("reset_settle_quiet", quiet, 0);

        // Saturating accumulation, simultaneous buttons, clear priority
        repeat (5) press(4'b1000, 1'b0, 1'b0);
        press(4'b0000, 1'b1, 1'b0);
        press(4'b0110, 1'b0, 1'b0);
        press(4'b1000, 1'b1, 1'b0);

        // Win, blackjack, tie rounds
        press(4'b0100, 1'b0, 1'b0);
        press(4'b0000, 1'b0, 1'b1);
        do_outcome(2'b10);
        press(4'b0100, 1'b0, 1'b0);
        press(4'b0010, 1'b0, 1'b0);
        press(4'b0000, 1'b0, 1'b1);
        do_outcome(2'b11);
        press(4'b0100, 1'b0, 1'b0);
        press(4'b0100, 1'b0, 1'b0);
        press(4'b0000, 1'b0, 1'b1);
        do_outcome(2'b01);

        // Outcome while betting and start with no bet are both ignored
        do_outcome(2'b10);
        press(4'b0000, 1'b0, 1'b1);

        // Losses down to negative saturation, then blackjacks up to positive
        repeat (26) set_bet99_round(2'b00);
        repeat (30) set_bet99_round(2'b11);

        // Buttons while locked are discarded; then reset mid-round
        press(4'b1000, 1'b0, 1'b0);
        press(4'b0000, 1'b0, 1'b1);
        press(4'b1111, 1'b1, 1'b0);
        press(4'b0101, 1'b0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        m_bet = 0; m_bank = START; m_locked = 1'b0;
        check_state("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset_broke", int'(broke_o), 0);

        // Random phase
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_outcome(2'($urandom));
            end else begin
                press(4'($urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0));
            end
        end
        if (m_locked) do_outcome(2'($urandom));

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bet_bank_ctrl.md
# bet_bank_ctrl

Parametrised betting and bankroll controller for the FPGA blackjack game. It takes any number of debounced push-button bet increments with configurable denominations, accumulates a saturating bet, and locks it for a round. On the game FSM's outcome report it settles the signed bankroll, including the 3:2 blackjack payout. It sits between the board buttons and the game state machine, and drives the bet and bank values for the seven-segment display blocks.

## Interface
- NUM_INC, 4, number of bet-increment buttons
- INC_VALS, {8'd25,8'd10,8'd5,8'd1}, packed NUM_INC×8-bit denominations; index i occupies bits [8i+7:8i]
- BET_W, 8, bet register width
- BET_MAX, 99, bet ceiling (≤ 2^BET_W−1)
- BANK_W, 12, signed bankroll width (two's complement)
- START_BANK, 200, bankroll after reset
- clk  in  1  system clock
- rst  in  1  reset rst, asynchronous, active-low; clock clk
- inc_btn  in  NUM_INC  raw level-high increment buttons, asynchronous to clk
- clear_btn  in  1  raw button; zeroes the bet while betting
- start_btn  in  1  raw button; locks the bet and begins the round
- outcome_valid  in  1  one-cycle pulse from the game FSM; synchronous to clk
- outcome  in  2  00 loss, 01 tie, 10 win, 11 blackjack win; sampled with outcome_valid
- bet  out  BET_W  current bet
- bank  out  BANK_W  signed bankroll
- round_active  out  1  high in LOCKED and SETTLE
- settle_valid  out  1  one-cycle pulse after the bank is credited
- broke  out  1  high when bank ≤ 0 (registered)

## Operation
- Each raw button passes through a 2-flop synchroniser and then a rising-edge detector (previous-value flop). One press produces one edge pulse, regardless of how long it is held.
- States: BETTING (reset state), LOCKED, SETTLE.
- BETTING:
  - Sum the INC_VALS of all buttons with an edge pulse this cycle, add the sum to bet, and saturate at BET_MAX. The sum is computed at BET_W+4 bits so it cannot overflow.
  - A clear edge sets bet to 0. Clear beats increments in the same cycle.
  - A start edge with bet ≠ 0: bank ← bank − bet, then go to LOCKED. Increment and clear edges in that same cycle are discarded, and the locked bet is the pre-cycle value.
  - A start edge with bet = 0 is ignored.
  - outcome_valid is ignored in BETTING.
- LOCKED:
  - Increment, clear and start edges are discarded.
  - outcome_valid → compute the payout, then go to SETTLE. Payout by outcome: loss 0; tie bet; win 2·bet; blackjack 2·bet + floor(bet/2).
- SETTLE (one cycle): bank ← bank + payout; bet ← 0; settle_valid = 1; then go to BETTING.
- Bank arithmetic:
  - Operands are sign-extended to BANK_W+1 bits.
  - The result saturates at −2^(BANK_W−1) and 2^(BANK_W−1)−1.
  - A negative bank is legal (the player is in debt); betting is not restricted by the bank value.
- broke is recomputed from bank every cycle and registered.

## Timing
- Reset values: bet 0, bank START_BANK, round_active 0, settle_valid 0, broke 0 (START_BANK > 0), state BETTING, all synchroniser and edge flops 0.
- Reset is asynchronous in every state, including mid-round; the locked bet is forfeited and the bank returns to START_BANK.
- Button latency: a button first sampled high at edge k produces its edge pulse in cycle k+1→k+2; bet, or the lock, is updated at edge k+2.
- outcome_valid sampled at edge n → state SETTLE during cycle n→n+1 → bank, bet and settle_valid updated at edge n+1 → broke updated at edge n+2.
- round_active goes high at the same edge the bank is debited, and goes low at the edge that leaves SETTLE.
- Buttons held across a state change generate no new edge.

## Test plan
- Reset → bet=0, bank=200, broke=0, round_active=0; settle_valid stays 0 for 20 cycles.
- Press inc_btn[3] (value 25) five times → bet 25, 50, 75, 99, 99. Press 5 and 10 in the same cycle from bet 0 → bet 15. Press clear and 25 together → bet 0.
- Bet 10, press start → bank 190, round_active=1. Outcome win → bank 210, bet 0, settle_valid high for exactly one cycle.
- Bet 15, outcome blackjack → bank 185, then 222. Bet 20, outcome tie → bank returns to its pre-bet value.
- Bet 99 with outcome loss, three rounds → bank 101, 2, −97; broke=1 after the third settle. Start with bet 0 → no state change.
- Bet 25 and start (bank 175). Press increments and start while LOCKED → bet stays 25. Assert rst low mid-round → bank 200, bet 0, BETTING.
